// File: rtl/pe_frame_loader.sv
// pe_frame_loader: assembles a serial 2-bit stream into the PE array's 18-bit filter and 128-bit image buses.
// Optional feature: define PE_LOADER_FILT_REUSE_EN to skip reloading an already valid filter.
module pe_frame_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [1:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
`ifdef PE_LOADER_FILT_REUSE_EN
  input  logic         filt_load,
`endif
  output logic [17:0]  filter_bus,
  output logic [127:0] in_bus,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, LOAD_FILT, LOAD_PIX, HOLD} state_t;
  state_t state_q, state_d, entry;
  logic [3:0] j_q, j_d;
  logic [6:0] k_q, k_d;
  logic [17:0] filter_q, filter_d;
  logic [127:0] in_q, in_d;
  logic s_ready_q, s_ready_d, frame_valid_q, frame_valid_d, busy_q, busy_d;
  logic acc;
`ifdef PE_LOADER_FILT_REUSE_EN
  logic filt_ok_q, filt_ok_d;
  assign entry = (filt_ok_q && !filt_load) ? LOAD_PIX : LOAD_FILT;
`else
  assign entry = LOAD_FILT;
`endif
  assign acc = s_valid & s_ready_q;
  assign s_ready = s_ready_q;
  assign frame_valid = frame_valid_q;
  assign busy = busy_q;
  assign filter_bus = filter_q;
  assign in_bus = in_q;
  // next-state logic: clr overrides every handshake and restarts the frame without touching the buses
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    k_d = k_q;
    filter_d = filter_q;
    in_d = in_q;
    frame_valid_d = frame_valid_q;
    busy_d = busy_q;
`ifdef PE_LOADER_FILT_REUSE_EN
    filt_ok_d = filt_ok_q;
`endif
    if (clr) begin
      state_d = entry;
      j_d = '0;
      k_d = '0;
      frame_valid_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = entry;
        LOAD_FILT: if (acc) begin
          filter_d[2*j_q +: 2] = s_data;
          busy_d = 1'b1;
          j_d = (j_q == 4'd8) ? 4'd0 : j_q + 4'd1;
          if (j_q == 4'd8) begin
            state_d = LOAD_PIX;
            k_d = '0;
`ifdef PE_LOADER_FILT_REUSE_EN
            filt_ok_d = 1'b1;
`endif
          end
        end
        LOAD_PIX: if (acc) begin
          in_d[2*k_q +: 2] = s_data;
          busy_d = k_q != 7'd63;
          k_d = (k_q == 7'd63) ? 7'd0 : k_q + 7'd1;
          if (k_q == 7'd63) begin
            state_d = HOLD;
            frame_valid_d = 1'b1;
          end
        end
        HOLD: if (frame_ready) begin
          state_d = entry;
          frame_valid_d = 1'b0;
          j_d = '0;
          k_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    s_ready_d = (state_d == LOAD_FILT) || (state_d == LOAD_PIX);
  end
  // state and registered outputs; reset clears everything including the reuse flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q <= '0;
      k_q <= '0;
      filter_q <= '0;
      in_q <= '0;
      s_ready_q <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef PE_LOADER_FILT_REUSE_EN
      filt_ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      k_q <= k_d;
      filter_q <= filter_d;
      in_q <= in_d;
      s_ready_q <= s_ready_d;
      frame_valid_q <= frame_valid_d;
      busy_q <= busy_d;
`ifdef PE_LOADER_FILT_REUSE_EN
      filt_ok_q <= filt_ok_d;
`endif
    end
  end
endmodule

// File: tb/tb_pe_frame_loader.sv
// tb_pe_frame_loader: randomized scoreboard bench; expected frames are built from the accepted element stream.
module tb_pe_frame_loader;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, s_valid = 1'b0, frame_ready = 1'b0;
  logic [1:0] s_data = 2'd0;
  logic s_ready, frame_valid, busy;
  logic [17:0] filter_bus;
  logic [127:0] in_bus;
`ifdef PE_LOADER_FILT_REUSE_EN
  logic filt_load = 1'b1;
`endif
  int vectors = 0, miscompares = 0, cyc = 0, last_fv = -1;
  bit b2b = 1'b0;
  logic [1:0] part[$];
  logic [17:0] ef_q[$];
  logic [127:0] ei_q[$];
  bit need_filt = 1'b1, m_ok = 1'b0;
  logic [17:0] m_filt = '0;

  pe_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef PE_LOADER_FILT_REUSE_EN
    .filt_load(filt_load),
`endif
    .filter_bus(filter_bus), .in_bus(in_bus), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: a frame is the next 73 accepted elements (64 when the filter is reused)
  task automatic model_beat(input logic [1:0] d);
    int len;
    logic [127:0] px;
    if (part.size() == 0) begin
`ifdef PE_LOADER_FILT_REUSE_EN
      need_filt = !m_ok || filt_load;
`else
      need_filt = 1'b1;
`endif
    end
    if (need_filt && part.size() < 9) m_filt[2*part.size() +: 2] = d;
    part.push_back(d);
    if (need_filt && part.size() == 9) m_ok = 1'b1;
    len = need_filt ? 73 : 64;
    if (part.size() == len) begin
      for (int i = 0; i < 64; i++) px[2*i +: 2] = part[len-64+i];
      ef_q.push_back(m_filt);
      ei_q.push_back(px);
      part.delete();
    end
  endtask

  task automatic model_clr();
    part.delete();
    ef_q.delete();
    ei_q.delete();
  endtask

  task automatic beat(input logic [1:0] d);
    int n = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!(s_ready && !clr) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: s_ready stayed %b, required 1", s_ready);
    end else model_beat(d);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input bit rnd, input bit gaps);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
      if (rnd) d = 2'($urandom);
      else if (n == 73 && i < 9) d = (i == 4) ? 2'd1 : 2'd0;
      else d = 2'(((n == 73) ? i - 9 : i) % 3);
      if (i == n - 1) chk("fv_before_last", frame_valid, 0);
      beat(d);
      if (i == 0) chk("busy_after_first", busy, 1);
      if (i == 0 && n == 73) chk("first_weight", filter_bus[1:0], d);
    end
    s_valid = 1'b0;
    chk("fv_after_last", frame_valid, 1);
    chk("busy_in_hold", busy, 0);
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    s_valid = 1'b1;
    s_data = 2'd2;
    model_clr();
    @(posedge clk); #1;
    clr = 1'b0;
    s_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_fv", frame_valid, 0);
    chk("clr_s_ready", s_ready, 1);
  endtask

  // monitor: pops the scoreboard on every frame handshake and polices HOLD behaviour
  always @(negedge clk) if (rst_n) begin
    cyc++;
    if (frame_valid) begin
      chk("s_ready_in_hold", s_ready, 0);
      if (b2b) begin
        if (last_fv >= 0) chk("fv_period", cyc - last_fv, 74);
        last_fv = cyc;
      end
    end
    if (frame_valid && frame_ready && !clr) begin
      if (ef_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: frame_valid 1, required no frame pending");
      end else begin
        chk("frame_filter", filter_bus, ef_q.pop_front());
        chk("frame_in", in_bus, ei_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_s_ready", s_ready, 0);
    @(posedge clk); #1;
    chk("s_ready_after_release", s_ready, 1);
    for (int i = 0; i < 20; i++) beat(2'd3);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_filter", filter_bus, 0);
    chk("rst_in", in_bus, 0);
    model_clr();
    m_ok = 1'b0;
    m_filt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_idle_s_ready", s_ready, 0);
    @(posedge clk); #1;
    chk("rst_release_s_ready", s_ready, 1);

    send_frame(73, 1'b0, 1'b0);
    chk("full_filter", filter_bus, 18'h00100);
    chk("full_in_0", in_bus[1:0], 0);
    chk("full_in_1", in_bus[3:2], 1);
    chk("full_in_63", in_bus[127:126], 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("frozen_fv", frame_valid, 1);
      chk("frozen_filter", filter_bus, ef_q[0]);
      chk("frozen_in", in_bus, ei_q[0]);
    end
    release_frame();

    send_frame(73, 1'b0, 1'b1);
    release_frame();

    for (int i = 0; i < 30; i++) beat(i == 0 ? 2'd3 : 2'($urandom));
    s_valid = 1'b0;
    do_clr();
    send_frame(73, 1'b0, 1'b1);
    frame_ready = 1'b1;
    do_clr();
    frame_ready = 1'b0;
    send_frame(73, 1'b1, 1'b1);
    release_frame();

    frame_ready = 1'b1;
    last_fv = -1;
    b2b = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(73, 1'b1, 1'b0);
    @(posedge clk); #1;
    frame_ready = 1'b0;
    b2b = 1'b0;

`ifdef PE_LOADER_FILT_REUSE_EN
    send_frame(73, 1'b0, 1'b0);
    filt_load = 1'b0;
    release_frame();
    send_frame(64, 1'b0, 1'b0);
    chk("reuse_filter", filter_bus, 18'h00100);
    filt_load = 1'b1;
    release_frame();
    send_frame(73, 1'b1, 1'b0);
    release_frame();
`endif

    repeat (3) @(posedge clk);
    #1 chk("leftover_frames", ef_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
